// File: rtl/act_weight_dispatcher_if.sv
// Handshake bundle for the activation/weight dispatcher: configuration, weight and
// activation-group inputs, and the leader output stream.
interface act_weight_dispatcher_if #(
    parameter int DATA_WIDTH             = 8,
    parameter int GROUP_SIZE             = 4,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16
);
    localparam int REP_INFO     = GROUP_SIZE * GROUP_SIZE;
    localparam int ZERO_INFO    = GROUP_SIZE;
    localparam int INPUT_WIDTH  = GROUP_SIZE * DATA_WIDTH + REP_INFO + ZERO_INFO;
    localparam int OUTPUT_WIDTH = 2 * DATA_WIDTH + REP_INFO + ZERO_INFO;

    logic                              configure;
    logic [LOG_MAX_ITERS-1:0]          num_iters;
    logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter;
    logic [INPUT_WIDTH-1:0]            act_data_in;
    logic                              act_valid_in;
    logic                              act_avail_out;
    logic [DATA_WIDTH-1:0]             weight_data_in;
    logic                              weight_valid_in;
    logic                              weight_avail_out;
    logic [OUTPUT_WIDTH-1:0]           data_out;
    logic                              valid_out;
    logic                              avail_in;

    modport master (
        output configure, num_iters, num_reads_per_iter,
        output act_data_in, act_valid_in, weight_data_in, weight_valid_in, avail_in,
        input  act_avail_out, weight_avail_out, data_out, valid_out
    );

    modport slave (
        input  configure, num_iters, num_reads_per_iter,
        input  act_data_in, act_valid_in, weight_data_in, weight_valid_in, avail_in,
        output act_avail_out, weight_avail_out, data_out, valid_out
    );
endinterface

// File: rtl/act_weight_dispatcher.sv
// Front-end of the sparse MAC path: latches a weight per iteration, then streams out
// only the unique, non-zero activations (leaders) of each incoming group.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | after reset, nothing accepted until configure
// WAIT_WEIGHT | weight_avail_out high, waiting for this iteration's weight
// WAIT_ACT    | act_avail_out high, waiting for the next activation group
// DISPATCH    | emitting pending leaders, one per free output slot
// DONE        | all iterations consumed, waiting for configure
module act_weight_dispatcher #(
    parameter int DATA_WIDTH             = 8,
    parameter int GROUP_SIZE             = 4,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    act_weight_dispatcher_if.slave    bus
);
    localparam int REP_INFO  = GROUP_SIZE * GROUP_SIZE;
    localparam int ZERO_INFO = GROUP_SIZE;
    localparam int VAL_BITS  = GROUP_SIZE * DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WEIGHT,
        WAIT_ACT,
        DISPATCH,
        DONE
    } state_t;

    state_t                            state;
    logic [LOG_MAX_ITERS-1:0]          iters_cfg;
    logic [LOG_MAX_READS_PER_ITER-1:0] reads_cfg;
    logic [LOG_MAX_ITERS-1:0]          iter_cnt;
    logic [LOG_MAX_READS_PER_ITER-1:0] read_cnt;
    logic [DATA_WIDTH-1:0]             weight_r;
    logic [VAL_BITS-1:0]               vals_r;
    logic [REP_INFO-1:0]               rep_r;
    logic [ZERO_INFO-1:0]              zero_r;
    logic [GROUP_SIZE-1:0]             leader_r;

    logic [REP_INFO-1:0]               in_rep;
    logic [ZERO_INFO-1:0]              in_zero;
    logic [GROUP_SIZE-1:0]             in_leader;
    logic [GROUP_SIZE-1:0]             lead_onehot;
    logic [GROUP_SIZE-1:0]             leader_next;
    logic [DATA_WIDTH-1:0]             lead_val;
    logic [LOG_MAX_ITERS-1:0]          iters_inc;
    logic [LOG_MAX_READS_PER_ITER-1:0] reads_inc;
    logic                              slot_free;
    logic                              group_end;

    assign in_rep  = bus.act_data_in[VAL_BITS +: REP_INFO];
    assign in_zero = bus.act_data_in[VAL_BITS + REP_INFO +: ZERO_INFO];

    // A leader is the first occurrence of its value (diagonal bit) and not zero.
    always_comb begin
        in_leader = '0;
        for (int k = 0; k < GROUP_SIZE; k++) begin
            in_leader[k] = in_rep[k * GROUP_SIZE + k] & ~in_zero[k];
        end
    end

    // Lowest pending leader wins so output order follows element index.
    always_comb begin
        lead_onehot = '0;
        lead_val    = '0;
        for (int k = GROUP_SIZE - 1; k >= 0; k--) begin
            if (leader_r[k]) begin
                lead_onehot    = '0;
                lead_onehot[k] = 1'b1;
                lead_val       = vals_r[k * DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign leader_next = leader_r & ~lead_onehot;
    assign slot_free   = !bus.valid_out || bus.avail_in;
    assign reads_inc   = read_cnt + 1'b1;
    assign iters_inc   = iter_cnt + 1'b1;
    assign group_end   = (state == DISPATCH) &&
                         ((leader_r == '0) || (slot_free && (leader_next == '0)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            iters_cfg            <= '0;
            reads_cfg            <= '0;
            iter_cnt             <= '0;
            read_cnt             <= '0;
            weight_r             <= '0;
            vals_r               <= '0;
            rep_r                <= '0;
            zero_r               <= '0;
            leader_r             <= '0;
            bus.data_out         <= '0;
            bus.valid_out        <= 1'b0;
            bus.act_avail_out    <= 1'b0;
            bus.weight_avail_out <= 1'b0;
        end else if (bus.configure) begin
            iters_cfg         <= bus.num_iters;
            reads_cfg         <= bus.num_reads_per_iter;
            iter_cnt          <= '0;
            read_cnt          <= '0;
            leader_r          <= '0;
            bus.valid_out     <= 1'b0;
            bus.act_avail_out <= 1'b0;
            if ((bus.num_iters == '0) || (bus.num_reads_per_iter == '0)) begin
                state                <= DONE;
                bus.weight_avail_out <= 1'b0;
            end else begin
                state                <= WAIT_WEIGHT;
                bus.weight_avail_out <= 1'b1;
            end
        end else begin
            // Drain the output slot; an emission below overrides this.
            if (bus.avail_in) begin
                bus.valid_out <= 1'b0;
            end

            case (state)
                WAIT_WEIGHT: begin
                    if (bus.weight_valid_in && bus.weight_avail_out) begin
                        weight_r             <= bus.weight_data_in;
                        bus.weight_avail_out <= 1'b0;
                        bus.act_avail_out    <= 1'b1;
                        state                <= WAIT_ACT;
                    end
                end
                WAIT_ACT: begin
                    if (bus.act_valid_in && bus.act_avail_out) begin
                        vals_r            <= bus.act_data_in[VAL_BITS-1:0];
                        rep_r             <= in_rep;
                        zero_r            <= in_zero;
                        leader_r          <= in_leader;
                        bus.act_avail_out <= 1'b0;
                        state             <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    if ((leader_r != '0) && slot_free) begin
                        bus.data_out  <= {zero_r, rep_r, weight_r, lead_val};
                        bus.valid_out <= 1'b1;
                        leader_r      <= leader_next;
                    end
                end
                default: ;
            endcase

            if (group_end) begin
                if (reads_inc < reads_cfg) begin
                    read_cnt          <= reads_inc;
                    bus.act_avail_out <= 1'b1;
                    state             <= WAIT_ACT;
                end else begin
                    read_cnt <= '0;
                    iter_cnt <= iters_inc;
                    if (iters_inc < iters_cfg) begin
                        bus.weight_avail_out <= 1'b1;
                        state                <= WAIT_WEIGHT;
                    end else begin
                        state <= DONE;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_act_weight_dispatcher.sv
// Directed bench for act_weight_dispatcher: reference outputs are hand-computed
// leader lists per group, compared in order against a record of output transfers.
module tb_act_weight_dispatcher;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [63:0] outq[$];

    act_weight_dispatcher_if bus ();
    act_weight_dispatcher dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Record every completed output transfer.
    always @(posedge clk) begin
        if (!rst && bus.valid_out === 1'b1 && bus.avail_in === 1'b1)
            outq.push_back(64'(bus.data_out));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_out(input logic [7:0] v, input logic [7:0] w,
                                           input logic [15:0] rep, input logic [3:0] zero);
        return 64'({zero, rep, w, v});
    endfunction

    function automatic logic [51:0] mk_grp(input logic [7:0] v0, input logic [7:0] v1,
                                           input logic [7:0] v2, input logic [7:0] v3,
                                           input logic [15:0] rep, input logic [3:0] zero);
        return {zero, rep, v3, v2, v1, v0};
    endfunction

    task automatic expect_out(input string tag, input logic [63:0] exp);
        logic [63:0] o;
        if (outq.size() > 0) o = outq.pop_front();
        else o = '1;
        check(tag, o, exp);
    endtask

    task automatic wait_for(input string tag, input bit act);
        int n = 0;
        while (((act ? bus.act_avail_out : bus.weight_avail_out) !== 1'b1) && n < 20) begin
            tick();
            n++;
        end
        check(tag, 64'(act ? bus.act_avail_out : bus.weight_avail_out), 64'd1);
    endtask

    task automatic do_configure(input logic [15:0] iters, input logic [15:0] reads);
        bus.configure          = 1'b1;
        bus.num_iters          = iters;
        bus.num_reads_per_iter = reads;
        tick();
        bus.configure = 1'b0;
    endtask

    task automatic send_weight(input logic [7:0] w);
        wait_for("weight_ready", 1'b0);
        bus.weight_data_in  = w;
        bus.weight_valid_in = 1'b1;
        tick();
        bus.weight_valid_in = 1'b0;
    endtask

    task automatic send_group(input logic [51:0] g);
        wait_for("act_ready", 1'b1);
        bus.act_data_in  = g;
        bus.act_valid_in = 1'b1;
        tick();
        bus.act_valid_in = 1'b0;
    endtask

    initial begin
        bus.configure          = 1'b0;
        bus.num_iters          = '0;
        bus.num_reads_per_iter = '0;
        bus.act_data_in        = '0;
        bus.act_valid_in       = 1'b0;
        bus.weight_data_in     = '0;
        bus.weight_valid_in    = 1'b0;
        bus.avail_in           = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_valid", 64'(bus.valid_out), 64'd0);
        check("rst_data", 64'(bus.data_out), 64'd0);
        check("rst_act_avail", 64'(bus.act_avail_out), 64'd0);
        check("rst_wt_avail", 64'(bus.weight_avail_out), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_wt_avail", 64'(bus.weight_avail_out), 64'd0);

        // Iteration 1: one leader per group
        do_configure(16'd2, 16'd4);
        check("cfg_wt_avail", 64'(bus.weight_avail_out), 64'd1);
        send_weight(8'd1);
        check("w1_wt_avail_low", 64'(bus.weight_avail_out), 64'd0);
        check("w1_act_avail", 64'(bus.act_avail_out), 64'd1);
        for (int g = 1; g <= 4; g++)
            send_group(mk_grp(8'(g), 8'(g), 8'(g), 8'(g), 16'h000F, 4'h0));
        wait_for("iter1_end_wt_ready", 1'b0);
        check("iter1_end_act_low", 64'(bus.act_avail_out), 64'd0);
        tick();
        tick();
        for (int g = 1; g <= 4; g++)
            expect_out("iter1_out", mk_out(8'(g), 8'd1, 16'h000F, 4'h0));
        check("iter1_count", 64'(outq.size()), 64'd0);

        // Iteration 2: zero mask and multi-leader groups
        send_weight(8'd2);
        for (int i = 0; i < 4; i++)
            send_group(mk_grp(8'd0, 8'(2 + i), 8'(1 + i), 8'(i), 16'h8420,
                              (i == 0) ? 4'b1001 : 4'b0001));
        tick(); tick(); tick(); tick(); tick();
        check("done_act_avail", 64'(bus.act_avail_out), 64'd0);
        check("done_wt_avail", 64'(bus.weight_avail_out), 64'd0);
        expect_out("iter2_g0_a", mk_out(8'd2, 8'd2, 16'h8420, 4'b1001));
        expect_out("iter2_g0_b", mk_out(8'd1, 8'd2, 16'h8420, 4'b1001));
        for (int i = 1; i < 4; i++) begin
            expect_out("iter2_a", mk_out(8'(2 + i), 8'd2, 16'h8420, 4'b0001));
            expect_out("iter2_b", mk_out(8'(1 + i), 8'd2, 16'h8420, 4'b0001));
            expect_out("iter2_c", mk_out(8'(i), 8'd2, 16'h8420, 4'b0001));
        end
        check("iter2_count", 64'(outq.size()), 64'd0);

        // Backpressure on a 3-leader group (element 2 repeats element 0)
        do_configure(16'd1, 16'd3);
        send_weight(8'd7);
        bus.avail_in = 1'b0;
        send_group(mk_grp(8'd10, 8'd20, 8'd10, 8'd40, 16'h8025, 4'h0));
        check("bp_first_latency", 64'(bus.valid_out), 64'd0);
        tick();
        check("bp_valid", 64'(bus.valid_out), 64'd1);
        check("bp_data", 64'(bus.data_out), mk_out(8'd10, 8'd7, 16'h8025, 4'h0));
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp_hold_valid", 64'(bus.valid_out), 64'd1);
            check("bp_hold_data", 64'(bus.data_out), mk_out(8'd10, 8'd7, 16'h8025, 4'h0));
        end
        bus.avail_in = 1'b1;
        wait_for("bp_act_ready", 1'b1);
        tick();
        expect_out("bp_out0", mk_out(8'd10, 8'd7, 16'h8025, 4'h0));
        expect_out("bp_out1", mk_out(8'd20, 8'd7, 16'h8025, 4'h0));
        expect_out("bp_out2", mk_out(8'd40, 8'd7, 16'h8025, 4'h0));
        check("bp_count", 64'(outq.size()), 64'd0);

        // All-zero group: one DISPATCH cycle, no output
        send_group(mk_grp(8'd0, 8'd0, 8'd0, 8'd0, 16'h8421, 4'hF));
        check("zero_act_low", 64'(bus.act_avail_out), 64'd0);
        tick();
        check("zero_act_back", 64'(bus.act_avail_out), 64'd1);
        check("zero_no_valid", 64'(bus.valid_out), 64'd0);
        send_group(mk_grp(8'd99, 8'd99, 8'd99, 8'd99, 16'h000F, 4'h0));
        tick(); tick(); tick();
        check("run3_done_act", 64'(bus.act_avail_out), 64'd0);
        check("run3_done_wt", 64'(bus.weight_avail_out), 64'd0);
        expect_out("run3_out", mk_out(8'd99, 8'd7, 16'h000F, 4'h0));
        check("run3_count", 64'(outq.size()), 64'd0);

        // num_iters = 0 goes straight to DONE
        do_configure(16'd0, 16'd3);
        check("zero_iters_wt", 64'(bus.weight_avail_out), 64'd0);
        tick(); tick();
        check("zero_iters_wt_hold", 64'(bus.weight_avail_out), 64'd0);
        check("zero_iters_act_hold", 64'(bus.act_avail_out), 64'd0);

        // Reset in the middle of DISPATCH, then restart
        do_configure(16'd1, 16'd1);
        send_weight(8'd5);
        send_group(mk_grp(8'd1, 8'd2, 8'd3, 8'd4, 16'h8421, 4'h0));
        tick();
        check("mid_valid", 64'(bus.valid_out), 64'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 64'(bus.valid_out), 64'd0);
        check("mid_rst_data", 64'(bus.data_out), 64'd0);
        check("mid_rst_act", 64'(bus.act_avail_out), 64'd0);
        check("mid_rst_wt", 64'(bus.weight_avail_out), 64'd0);
        rst = 1'b0;
        tick();
        outq.delete();
        do_configure(16'd1, 16'd1);
        check("restart_wt_avail", 64'(bus.weight_avail_out), 64'd1);
        send_weight(8'd6);
        send_group(mk_grp(8'd9, 8'd9, 8'd9, 8'd9, 16'h000F, 4'h0));
        tick(); tick(); tick();
        expect_out("restart_out", mk_out(8'd9, 8'd6, 16'h000F, 4'h0));
        check("restart_count", 64'(outq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/act_weight_dispatcher.md
Name: act_weight_dispatcher

Overview:
- Front-end of the sparse/repetition-aware MAC path.
- Latches one weight per iteration, then accepts `num_reads_per_iter` activation groups for that iteration. A group is GROUP_SIZE values plus a repetition matrix and a zero mask.
- Emits one output word per unique, non-zero activation in each group, skipping repeated and zero values.
- Each output word carries the value, the current weight and the group's repetition/zero metadata for downstream accumulation.

Parameters:
- DATA_WIDTH, 8, bits per activation and per weight.
- GROUP_SIZE, 4, activations per group.
- LOG_MAX_ITERS, 16, width of `num_iters`.
- LOG_MAX_READS_PER_ITER, 16, width of `num_reads_per_iter`.
- Derived REP_INFO = GROUP_SIZE*GROUP_SIZE, ZERO_INFO = GROUP_SIZE.
- Derived INPUT_WIDTH = GROUP_SIZE*DATA_WIDTH + REP_INFO + ZERO_INFO.
- Derived OUTPUT_WIDTH = 2*DATA_WIDTH + REP_INFO + ZERO_INFO.

Ports:
- clk  in  1  clock, rising edge; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- configure  in  1  latch num_iters / num_reads_per_iter and restart.
- num_iters  in  LOG_MAX_ITERS  iterations (weights) per run.
- num_reads_per_iter  in  LOG_MAX_READS_PER_ITER  activation groups per iteration.
- act_data_in  in  INPUT_WIDTH  [G*DW-1:0] values, element k at [k*DW+:DW]; next REP_INFO bits: repetition matrix; top ZERO_INFO bits: zero mask.
- act_valid_in  in  1  activation group valid.
- act_avail_out  out  1  ready to accept an activation group.
- weight_data_in  in  DATA_WIDTH  weight.
- weight_valid_in  in  1  weight valid.
- weight_avail_out  out  1  ready to accept a weight.
- data_out  out  OUTPUT_WIDTH  [DW-1:0] activation value; [2DW-1:DW] weight; next REP_INFO bits: group repetition matrix; top ZERO_INFO bits: group zero mask.
- valid_out  out  1  data_out valid.
- avail_in  in  1  downstream ready.

Behaviour:
- Handshakes: a transfer occurs on a rising edge where valid and avail are both 1.
- Reset (rst=1 at edge): state IDLE. valid_out, data_out, act_avail_out and weight_avail_out are all 0. Counters and weight register cleared. Any in-flight group is discarded.
- State IDLE: all avail outputs 0.
- configure=1 (any state, rst low):
  - Latch both counts, clear the iteration and read counters, clear valid_out.
  - Go to WAIT_WEIGHT, or to DONE if either count is 0.
- WAIT_WEIGHT: weight_avail_out=1. On transfer, register the weight and go to WAIT_ACT.
- WAIT_ACT: act_avail_out=1. On transfer, register the whole group, build the leader mask, and go to DISPATCH.
  - Repetition matrix bit [i*G+j] means element j equals element i (row i = first occurrence).
  - Element k is a leader iff rep[k*G+k]=1 and zero[k]=0. The zero mask takes precedence.
- DISPATCH:
  - Emit when the output slot is free: !valid_out or avail_in.
  - On each emitting edge, load the lowest pending leader into data_out: value, current weight, the unmodified rep matrix and zero mask. Set valid_out=1 and clear that leader.
  - Throughput is one leader per edge; non-leaders cost no cycles.
  - When the leader mask is empty after this edge, or was empty on entry (one cycle, no output), increment the read counter, then:
    - reads < num_reads_per_iter: go to WAIT_ACT;
    - else clear reads and increment iters;
    - iters < num_iters: go to WAIT_WEIGHT;
    - else go to DONE.
- Output slot: valid_out=1 with avail_in=0 holds data_out stable and stalls DISPATCH. If no new emission on a free edge, valid_out falls to 0.
- DONE: all avail outputs 0. Wait for configure.
- Latency: with group accepted at edge E and avail_in=1, the first leader appears after edge E+1 and leader n after edge E+n. act_avail_out is high again after the final emitting edge.
- Only one of act_avail_out / weight_avail_out is high at a time. No prefetch.

Test Plan:
- Reset, then configure with num_iters=2, reads=4; weight 1 -> weight_avail_out=1 then 0. Groups {1,1,1,1}…{4,4,4,4} with rep bits [3:0]=1111, zero=0 -> exactly four outputs, value 1..4, weight 1, one per group. Then weight_avail_out=1.
- Iteration 2: weight 2; groups values {0,2+i,1+i,i}, i=0..3, rep = diagonals 5,10,15, zero = {elem0, and elem3 when i=0} -> i=0 emits 2,1; i=1..3 emit (2+i),(1+i),i; weight field 2 on all; then DONE, both avail=0.
- Backpressure: avail_in=0 for 3 cycles during a 3-leader group -> data_out frozen. No leader is lost or duplicated, and order is element index ascending.
- Group with all elements zero -> no output, one cycle in DISPATCH, read counter advances.
- num_iters=0 on configure -> DONE immediately; no avail asserted.
- rst=1 mid-DISPATCH -> next cycle valid_out=0 and all avail=0; configure restarts cleanly.
